alu_mdu: RTL and testbench

//  Parametrised multi-cycle execute unit for the MIPS core: single-cycle ALU ops plus iterative mul/div.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_md_iter.sv | 138 +++++++++++++
 rtl/alu_mdu.sv | 151 +++++++++++++++
 tb/tb_alu_mdu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Opcodes, FSM states and flag bundle for the alu_mdu execute unit.
//             Optional macro ALU_SIGNED_MD_EN enables signed MUL/DIV opcodes.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_sltu = 4'b0000;
    localparam logic [3:0] c_op_slt  = 4'b0001;
    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam logic [3:0] c_op_and  = 4'b0011;
    localparam logic [3:0] c_op_or   = 4'b0100;
    localparam logic [3:0] c_op_xor  = 4'b0101;
    localparam logic [3:0] c_op_sub  = 4'b0110;
    localparam logic [3:0] c_op_nor  = 4'b0111;
    localparam logic [3:0] c_op_sll  = 4'b1000;
    localparam logic [3:0] c_op_srl  = 4'b1001;
    localparam logic [3:0] c_op_sra  = 4'b1010;
    localparam logic [3:0] c_op_mulu = 4'b1100;
    localparam logic [3:0] c_op_mul  = 4'b1101;
    localparam logic [3:0] c_op_divu = 4'b1110;
    localparam logic [3:0] c_op_div  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic div_zero;
        logic op_err;
    } alu_flags_t;

    // Multi-cycle opcodes; the signed pair only exists when the macro is set.
    function automatic logic is_md_op(input logic [3:0] op);
`ifdef ALU_SIGNED_MD_EN
        return (op == c_op_mulu) || (op == c_op_divu) ||
               (op == c_op_mul)  || (op == c_op_div);
`else
        return (op == c_op_mulu) || (op == c_op_divu);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_iter
//  Brief    : 1-bit/cycle shift-add multiplier and restoring divider with
//             optional sign fix-up (ALU_SIGNED_MD_EN).
//  Revision : 1.0  initial release
// ============================================================================
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
`ifdef ALU_SIGNED_MD_EN
    input  logic             is_signed_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             div_zero_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

    logic             busy_q;
    logic             is_div_q;
    logic             dz_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] low_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] low_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef ALU_SIGNED_MD_EN
    logic neg_lo_q;
    logic neg_hi_q;
    logic neg_lo_d;
    logic neg_hi_d;
`endif

    // acc holds the product high half (mul) or partial remainder (div);
    // low holds the multiplier shifting out or the quotient shifting in.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, {WIDTH{low_q[0]}} & opb_q};
        div_shift = {acc_q, low_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_d = div_trial[WIDTH-1:0];
                low_d = {low_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                low_d = {low_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        mag_a = a_i;
        mag_b = b_i;
`ifdef ALU_SIGNED_MD_EN
        neg_lo_d = 1'b0;
        neg_hi_d = 1'b0;
        // A zero divisor keeps the raw operands so the unsigned rule applies.
        if (is_signed_i && !(is_div_i && (b_i == '0))) begin
            if (a_i[WIDTH-1]) mag_a = -a_i;
            if (b_i[WIDTH-1]) mag_b = -b_i;
            neg_lo_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_hi_d = is_div_i ? a_i[WIDTH-1] : (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end
`endif
    end

    always_comb begin
        lo_o = low_d;
        hi_o = acc_d;
`ifdef ALU_SIGNED_MD_EN
        if (!is_div_q) begin
            if (neg_lo_q) {hi_o, lo_o} = -{acc_d, low_d};
        end else begin
            if (neg_lo_q) lo_o = -low_d;
            if (neg_hi_q) hi_o = -acc_d;
        end
`endif
    end

    assign done_o     = busy_q && (cnt_q == c_last);
    assign div_zero_o = dz_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
`ifdef ALU_SIGNED_MD_EN
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else if (start_i) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div_i;
            dz_q     <= is_div_i && (b_i == '0);
            cnt_q    <= '0;
            opb_q    <= mag_b;
            acc_q    <= '0;
            low_q    <= mag_a;
`ifdef ALU_SIGNED_MD_EN
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end else if (busy_q) begin
            acc_q <= acc_d;
            low_q <= low_d;
            cnt_q <= cnt_q + SHW'(1);
            if (cnt_q == c_last) busy_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Brief    : EX-stage ALU with iterative mul/div behind valid/ready; HI/LO.
//             Macro ALU_SIGNED_MD_EN adds signed MUL (1101) / DIV (1111).
//  Revision : 1.0  initial release
// ============================================================================
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ct,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] hi,
    output logic             alu_zero,
    output logic             alu_ovf,
    output logic             div_zero,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    alu_flags_t       flags_q;

    logic [WIDTH-1:0] res_d;
    alu_flags_t       flags_d;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             is_md;
    logic             md_start;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign shamt    = alu_src2[SHW-1:0];
    assign sum      = alu_src1 + alu_src2;
    assign diff     = alu_src1 - alu_src2;
    assign is_md    = is_md_op(alu_ct);
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_md;

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        case (alu_ct)
            c_op_sltu: res_d = {{(WIDTH-1){1'b0}}, (alu_src1 < alu_src2)};
            c_op_slt:  res_d = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
            c_op_add: begin
                res_d       = sum;
                flags_d.ovf = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) &&
                              (sum[WIDTH-1] != alu_src1[WIDTH-1]);
            end
            c_op_and:  res_d = alu_src1 & alu_src2;
            c_op_or:   res_d = alu_src1 | alu_src2;
            c_op_xor:  res_d = alu_src1 ^ alu_src2;
            c_op_sub: begin
                res_d       = diff;
                flags_d.ovf = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                              (diff[WIDTH-1] != alu_src1[WIDTH-1]);
            end
            c_op_nor:  res_d = ~(alu_src1 | alu_src2);
            c_op_sll:  res_d = alu_src1 << shamt;
            c_op_srl:  res_d = alu_src1 >> shamt;
            c_op_sra:  res_d = $signed(alu_src1) >>> shamt;
            // Mul/div codes land here too but never use this path.
            default:   flags_d.op_err = 1'b1;
        endcase
        flags_d.zero = (res_d == '0);
    end

    alu_md_iter #(
        .WIDTH(WIDTH)
    ) u_md_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (md_start),
        .is_div_i   (alu_ct[1]),
`ifdef ALU_SIGNED_MD_EN
        .is_signed_i(alu_ct[0]),
`endif
        .a_i        (alu_src1),
        .b_i        (alu_src2),
        .done_o     (md_done),
        .lo_o       (md_lo),
        .hi_o       (md_hi),
        .div_zero_o (md_dz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    if (md_done) begin
                        res_q            <= md_lo;
                        hi_q             <= md_hi;
                        flags_q.zero     <= (md_lo == '0);
                        flags_q.ovf      <= 1'b0;
                        flags_q.div_zero <= md_dz;
                        flags_q.op_err   <= 1'b0;
                        state_q          <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // A new request overrides the IDLE/DONE transition above.
            if (accept) begin
                if (is_md) begin
                    state_q <= S_BUSY;
                end else begin
                    res_q   <= res_d;
                    flags_q <= flags_d;
                    state_q <= S_DONE;
                end
            end
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign alu_res   = res_q;
    assign hi        = hi_q;
    assign alu_zero  = flags_q.zero;
    assign alu_ovf   = flags_q.ovf;
    assign div_zero  = flags_q.div_zero;
    assign op_err    = flags_q.op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_mdu
//  Brief    : Scoreboard bench for alu_mdu with directed vectors
//             (signed MUL/DIV vectors when ALU_SIGNED_MD_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   alu_ct    = 4'd0;
    logic [W-1:0] alu_src1  = '0;
    logic [W-1:0] alu_src2  = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] alu_res;
    logic [W-1:0] hi;
    logic         alu_zero;
    logic         alu_ovf;
    logic         div_zero;
    logic         op_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ovf;
        logic         dz;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    string        tag_q[$];
    logic [W-1:0] model_hi = '0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ct   (alu_ct),
        .alu_src1 (alu_src1),
        .alu_src2 (alu_src2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_res  (alu_res),
        .hi       (hi),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf),
        .div_zero (div_zero),
        .op_err   (op_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Result monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual res %h required none", alu_res);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, {alu_res, hi, alu_zero, alu_ovf, div_zero, op_err}, e);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e, output int waited);
        waited   = 0;
        alu_ct   = op;
        alu_src1 = a;
        alu_src2 = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL %s_accept: actual no handshake required handshake", name);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        exp_q.push_back(e);
        tag_q.push_back(name);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic alu(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic z,
                       input logic ovf, input logic err, output int waited);
        issue(name, op, a, b, {res, model_hi, z, ovf, 1'b0, err}, waited);
    endtask

    task automatic md(input string name, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] h,
                      input logic dz);
        int w;
        model_hi = h;
        issue(name, op, a, b, {res, h, (res == '0), 1'b0, dz, 1'b0}, w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int           w;
        int           tot;
        int           bad;
        logic [69:0]  snap;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, alu_res, hi, alu_zero, alu_ovf, div_zero, op_err},
              {1'b1, 1'b0, 68'd0});
        @(posedge clk); #1;

        alu("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        check("add_latency", 128'(out_valid), 128'd1);
        @(posedge clk); #1;

        tot = 0;
        alu("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, w);                       tot += w;
        alu("sltu", 4'b0000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, w);                    tot += w;
        alu("slt", 4'b0001, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, w);                     tot += w;
        alu("undef_1011", 4'b1011, 32'h1234_5678, 32'h9, 32'd0, 1'b1, 1'b0, 1'b1, w);              tot += w;
        alu("and", 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, w);    tot += w;
        alu("or", 4'b0100, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, w);     tot += w;
        alu("xor", 4'b0101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, w);    tot += w;
        alu("nor", 4'b0111, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, w);                     tot += w;
        alu("sll31", 4'b1000, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, w);                  tot += w;
        alu("srl_hi_bits", 4'b1001, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0, 1'b0, w);    tot += w;
        alu("sra", 4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0, w);             tot += w;
        alu("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, w);         tot += w;
        alu("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, w);                tot += w;
        check("b2b_throughput", 128'(tot), 128'd0);

        md("mulu", 4'b1100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0);
        bad = 0;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) bad++;
        end
        check("mulu_busy_window", 128'(bad), 128'd0);
        @(negedge clk);
        check("mulu_latency", 128'(out_valid), 128'd1);
        @(posedge clk); #1;

        md("divu", 4'b1110, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        md("divu_by_zero", 4'b1110, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1);
        alu("hi_kept", 4'b0100, 32'h0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, w);
        drain();

        out_ready = 1'b0;
        alu("sub_stalled", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        snap = {in_ready, out_valid, alu_res, hi, alu_zero, alu_ovf, div_zero, op_err};
        bad  = (out_valid && !in_ready) ? 0 : 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({in_ready, out_valid, alu_res, hi, alu_zero, alu_ovf, div_zero, op_err} !== snap) bad++;
        end
        check("stall_hold", 128'(bad), 128'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        alu("accept_on_drain", 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 1'b0, w);
        check("same_cycle_accept", 128'(w), 128'd0);
        @(negedge clk);
        check("post_drain_latency", 128'(out_valid), 128'd1);
        @(posedge clk); #1;
        drain();

        md("mulu_aborted", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        tag_q.delete();
        model_hi = '0;
        @(negedge clk);
        check("busy_reset", {in_ready, out_valid, alu_res, hi, alu_zero, alu_ovf, div_zero, op_err},
              {1'b1, 1'b0, 68'd0});
        @(posedge clk); #1;
        md("mulu_after_reset", 4'b1100, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0);

`ifdef ALU_SIGNED_MD_EN
        md("mul_signed", 4'b1101, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
        md("div_signed", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        md("div_signed_by_zero", 4'b1111, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
        alu("undef_1101", 4'b1101, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1, w);
        alu("undef_1111", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 1'b0, 1'b1, w);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
